// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: next-PC select codes (shared with
// control), instruction field layout, the canonical NOP and enable levels.
package fetch_unit_pkg;

    // Next-PC select codes driven by control.
    localparam int PC_OP_W = 2;
    localparam logic [PC_OP_W-1:0] PC_OP_DEFAULT = 2'b00;
    localparam logic [PC_OP_W-1:0] PC_OP_BRANCH  = 2'b01;
    localparam logic [PC_OP_W-1:0] PC_OP_JAL     = 2'b10;
    localparam logic [PC_OP_W-1:0] PC_OP_JALR    = 2'b11;

    // Instruction field widths and bit positions.
    localparam int INSTRUCTION_OPCODE_W   = 7;
    localparam int INSTRUCTION_FUNCT3_W   = 3;
    localparam int INSTRUCTION_FUNCT7_W   = 7;
    localparam int INSTRUCTION_OPCODE_LSB = 0;
    localparam int INSTRUCTION_FUNCT3_LSB = 12;
    localparam int INSTRUCTION_FUNCT7_LSB = 25;

    // addi x0, x0, 0 -- what the stage presents when nothing is held.
    localparam logic [31:0] INSTRUCTION_NOP = 32'h0000_0013;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // True when an address points at the start of a 32-bit word.
    function automatic logic word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection and target alignment check. Kept separate
// so branch prediction can reuse the same target arithmetic.
module pc_next
    import fetch_unit_pkg::*;
(
    input  logic [31:0]        pc,
    input  logic [PC_OP_W-1:0] pc_op,
    input  logic [31:0]        imm_b,
    input  logic [31:0]        imm_j,
    input  logic [31:0]        imm_i,
    input  logic [31:0]        rs1_data,
    output logic [31:0]        next_pc,
    output logic               misaligned
);

    // Select the successor address; unknown codes fall through to pc + 4.
    always_comb begin
        next_pc = pc + 32'd4;
        case (pc_op)
            PC_OP_DEFAULT: next_pc = pc + 32'd4;
            PC_OP_BRANCH:  next_pc = pc + imm_b;
            PC_OP_JAL:     next_pc = pc + imm_j;
            PC_OP_JALR:    next_pc = (rs1_data + imm_i) & ~32'h1;
            default:       next_pc = pc + 32'd4;
        endcase
    end

    assign misaligned = ~word_aligned(next_pc);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a
// req/ack handshake, holds it for decode until retire, then steers to the
// next PC. A misaligned target parks the stage in HALT until reset.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    output logic                            imem_req,
    output logic [31:0]                     imem_addr,
    input  logic                            imem_ack,
    input  logic [31:0]                     imem_rdata,
    input  logic                            retire,
    input  logic [PC_OP_W-1:0]              pc_op,
    input  logic [31:0]                     imm_b,
    input  logic [31:0]                     imm_j,
    input  logic [31:0]                     imm_i,
    input  logic [31:0]                     rs1_data,
    output logic                            inst_valid,
    output logic [31:0]                     inst,
    output logic [INSTRUCTION_OPCODE_W-1:0] opcode,
    output logic [INSTRUCTION_FUNCT3_W-1:0] funct3,
    output logic [INSTRUCTION_FUNCT7_W-1:0] funct7,
    output logic [31:0]                     pc,
    output logic [31:0]                     pc_plus4,
    output logic                            fetch_misaligned
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        HALT  = 2'b11
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        inst_valid_q;
    logic        misaligned_q;
    logic [31:0] next_pc;
    logic        target_misaligned;

    pc_next u_pc_next (
        .pc         (pc_q),
        .pc_op      (pc_op),
        .imm_b      (imm_b),
        .imm_j      (imm_j),
        .imm_i      (imm_i),
        .rs1_data   (rs1_data),
        .next_pc    (next_pc),
        .misaligned (target_misaligned)
    );

    // State register; reset drops straight to IDLE so imem_req falls at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: ack matters only in FETCH, retire only in HOLD.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (imem_ack) state_next = HOLD;
            HOLD:    if (retire) state_next = target_misaligned ? HALT : FETCH;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // Capture fetched words, advance the PC on retire and latch misalignment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            inst_q       <= INSTRUCTION_NOP;
            inst_valid_q <= DISABLE;
            misaligned_q <= DISABLE;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        inst_q       <= imem_rdata;
                        inst_valid_q <= ENABLE;
                    end
                end
                HOLD: begin
                    if (retire) begin
                        inst_q       <= INSTRUCTION_NOP;
                        inst_valid_q <= DISABLE;
                        if (target_misaligned) begin
                            misaligned_q <= ENABLE;
                        end else begin
                            pc_q <= next_pc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req         = (state == FETCH) ? ENABLE : DISABLE;
    assign imem_addr        = pc_q;
    assign inst             = inst_q;
    assign inst_valid       = inst_valid_q;
    assign opcode           = inst_q[INSTRUCTION_OPCODE_LSB +: INSTRUCTION_OPCODE_W];
    assign funct3           = inst_q[INSTRUCTION_FUNCT3_LSB +: INSTRUCTION_FUNCT3_W];
    assign funct7           = inst_q[INSTRUCTION_FUNCT7_LSB +: INSTRUCTION_FUNCT7_W];
    assign pc               = pc_q;
    assign pc_plus4         = pc_q + 32'd4;
    assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: reset, fetch handshakes, every next-PC
// select, wrap-around, misalignment halt and asynchronous reset mid-fetch.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic                            clk;
    logic                            rst_n;
    logic                            imem_req;
    logic [31:0]                     imem_addr;
    logic                            imem_ack;
    logic [31:0]                     imem_rdata;
    logic                            retire;
    logic [PC_OP_W-1:0]              pc_op;
    logic [31:0]                     imm_b;
    logic [31:0]                     imm_j;
    logic [31:0]                     imm_i;
    logic [31:0]                     rs1_data;
    logic                            inst_valid;
    logic [31:0]                     inst;
    logic [INSTRUCTION_OPCODE_W-1:0] opcode;
    logic [INSTRUCTION_FUNCT3_W-1:0] funct3;
    logic [INSTRUCTION_FUNCT7_W-1:0] funct7;
    logic [31:0]                     pc;
    logic [31:0]                     pc_plus4;
    logic                            fetch_misaligned;

    int assertCount = 0;
    int failCount   = 0;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .retire           (retire),
        .pc_op            (pc_op),
        .imm_b            (imm_b),
        .imm_j            (imm_j),
        .imm_i            (imm_i),
        .rs1_data         (rs1_data),
        .inst_valid       (inst_valid),
        .inst             (inst),
        .opcode           (opcode),
        .funct3           (funct3),
        .funct7           (funct7),
        .pc               (pc),
        .pc_plus4         (pc_plus4),
        .fetch_misaligned (fetch_misaligned)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                                 input logic ret, input logic [PC_OP_W-1:0] op,
                                 input logic [31:0] b, input logic [31:0] j,
                                 input logic [31:0] i, input logic [31:0] rs1);
        imem_ack   = ack;
        imem_rdata = rdata;
        retire     = ret;
        pc_op      = op;
        imm_b      = b;
        imm_j      = j;
        imm_i      = i;
        rs1_data   = rs1;
    endtask

    // Advance one cycle, landing on the falling edge where outputs are sampled.
    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // From HOLD: retire with the given select, expect a fetch at expAddr,
    // then complete that fetch with a zero-wait ack.
    task automatic retireTo(input string tag, input logic [PC_OP_W-1:0] op,
                            input logic [31:0] b, input logic [31:0] j,
                            input logic [31:0] i, input logic [31:0] rs1,
                            input logic [31:0] expAddr);
        applyStimulus(1'b0, 32'h0, 1'b1, op, b, j, i, rs1);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, PC_OP_DEFAULT, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput({tag, "_req"}, {31'h0, imem_req}, 32'h1);
        checkOutput({tag, "_addr"}, imem_addr, expAddr);
        checkOutput({tag, "_valid_low"}, {31'h0, inst_valid}, 32'h0);
        applyStimulus(1'b1, 32'h0000_0013, 1'b0, PC_OP_DEFAULT, 32'h0, 32'h0, 32'h0, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, PC_OP_DEFAULT, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput({tag, "_hold_pc"}, pc, expAddr);
        checkOutput({tag, "_misalign"}, {31'h0, fetch_misaligned}, 32'h0);
    endtask

    // Main directed sequence.
    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, PC_OP_DEFAULT, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (2) stepCycle();

        $display("[TB] reset state");
        checkOutput("rst_req", {31'h0, imem_req}, 32'h0);
        checkOutput("rst_valid", {31'h0, inst_valid}, 32'h0);
        checkOutput("rst_inst", inst, 32'h0000_0013);
        checkOutput("rst_pc", pc, 32'h0000_0100);
        checkOutput("rst_pc_plus4", pc_plus4, 32'h0000_0104);
        checkOutput("rst_misalign", {31'h0, fetch_misaligned}, 32'h0);

        $display("[TB] first fetch, ack held high from IDLE");
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h40B5_0533, 1'b0, PC_OP_DEFAULT, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("idle_req", {31'h0, imem_req}, 32'h0);
        stepCycle();
        checkOutput("fetch_req", {31'h0, imem_req}, 32'h1);
        checkOutput("fetch_addr", imem_addr, 32'h0000_0100);
        checkOutput("idle_ack_ignored", inst, 32'h0000_0013);
        checkOutput("fetch_valid_low", {31'h0, inst_valid}, 32'h0);
        stepCycle();
        checkOutput("hold_valid", {31'h0, inst_valid}, 32'h1);
        checkOutput("hold_inst", inst, 32'h40B5_0533);
        checkOutput("hold_opcode", {25'h0, opcode}, 32'h33);
        checkOutput("hold_funct3", {29'h0, funct3}, 32'h0);
        checkOutput("hold_funct7", {25'h0, funct7}, 32'h20);
        checkOutput("hold_req", {31'h0, imem_req}, 32'h0);

        $display("[TB] stray ack in HOLD");
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, PC_OP_DEFAULT, 32'h0, 32'h0, 32'h0, 32'h0);
        stepCycle();
        checkOutput("stray_inst", inst, 32'h40B5_0533);
        checkOutput("stray_valid", {31'h0, inst_valid}, 32'h1);
        checkOutput("stray_req", {31'h0, imem_req}, 32'h0);

        $display("[TB] default retire then delayed ack with retire in FETCH");
        applyStimulus(1'b0, 32'h0, 1'b1, PC_OP_DEFAULT, 32'h0, 32'h0, 32'h0, 32'h0);
        stepCycle();
        checkOutput("dflt_req", {31'h0, imem_req}, 32'h1);
        checkOutput("dflt_addr", imem_addr, 32'h0000_0104);
        checkOutput("dflt_inst_nop", inst, 32'h0000_0013);
        applyStimulus(1'b0, 32'h0, 1'b1, PC_OP_JAL, 32'h0, 32'h1000, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            checkOutput("wait_req", {31'h0, imem_req}, 32'h1);
            checkOutput("wait_addr", imem_addr, 32'h0000_0104);
            checkOutput("wait_valid", {31'h0, inst_valid}, 32'h0);
        end
        applyStimulus(1'b1, 32'h0000_006F, 1'b0, PC_OP_DEFAULT, 32'h0, 32'h0, 32'h0, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, PC_OP_DEFAULT, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("late_valid", {31'h0, inst_valid}, 32'h1);
        checkOutput("late_pc", pc, 32'h0000_0104);
        checkOutput("late_opcode", {25'h0, opcode}, 32'h6F);

        $display("[TB] next-PC selects");
        retireTo("jal_fc", PC_OP_JAL, 32'h0, 32'h0000_00FC, 32'h0, 32'h0, 32'h0000_0200);
        retireTo("branch_m8", PC_OP_BRANCH, 32'hFFFF_FFF8, 32'h0, 32'h0, 32'h0, 32'h0000_01F8);
        retireTo("jalr_clr", PC_OP_JALR, 32'h0, 32'h0, 32'h0, 32'h0000_0201, 32'h0000_0200);
        retireTo("jal_40", PC_OP_JAL, 32'h0, 32'h0000_0040, 32'h0, 32'h0, 32'h0000_0240);
        retireTo("jalr_sum", PC_OP_JALR, 32'h0, 32'h0, 32'h0000_0040, 32'h0000_01C0, 32'h0000_0200);
        retireTo("default", PC_OP_DEFAULT, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0204);

        $display("[TB] wrap-around");
        retireTo("to_top", PC_OP_JALR, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        checkOutput("top_pc_plus4", pc_plus4, 32'h0000_0000);
        retireTo("wrap", PC_OP_DEFAULT, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0000);

        $display("[TB] misaligned JALR target");
        retireTo("jalr_200", PC_OP_JALR, 32'h0, 32'h0, 32'h0, 32'h0000_0200, 32'h0000_0200);
        applyStimulus(1'b0, 32'h0, 1'b1, PC_OP_JALR, 32'h0, 32'h0, 32'h0, 32'h0000_1003);
        stepCycle();
        applyStimulus(1'b1, 32'h1234_5678, 1'b1, PC_OP_DEFAULT, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("halt_flag", {31'h0, fetch_misaligned}, 32'h1);
        checkOutput("halt_pc", pc, 32'h0000_0200);
        checkOutput("halt_inst", inst, 32'h0000_0013);
        checkOutput("halt_valid", {31'h0, inst_valid}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("halt_req", {31'h0, imem_req}, 32'h0);
            stepCycle();
        end
        checkOutput("halt_flag_sticky", {31'h0, fetch_misaligned}, 32'h1);
        checkOutput("halt_inst_still_nop", inst, 32'h0000_0013);

        $display("[TB] reset mid-fetch");
        applyStimulus(1'b0, 32'h0, 1'b0, PC_OP_DEFAULT, 32'h0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst2_flag", {31'h0, fetch_misaligned}, 32'h0);
        checkOutput("rst2_pc", pc, 32'h0000_0100);
        @(negedge clk);
        rst_n = 1'b1;
        stepCycle();
        checkOutput("rst2_fetch_req", {31'h0, imem_req}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_req_drop", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst3_idle_req", {31'h0, imem_req}, 32'h0);
        stepCycle();
        checkOutput("rst3_req", {31'h0, imem_req}, 32'h1);
        checkOutput("rst3_addr", imem_addr, 32'h0000_0100);
        applyStimulus(1'b1, 32'h0000_0093, 1'b0, PC_OP_DEFAULT, 32'h0, 32'h0, 32'h0, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, PC_OP_DEFAULT, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("rst3_valid", {31'h0, inst_valid}, 32'h1);
        checkOutput("rst3_inst", inst, 32'h0000_0093);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-issue core. Owns the program counter and issues word requests to instruction memory over a req/ack handshake. Holds the fetched instruction stable, split into opcode/funct3/funct7, for the decode/control stage until the core retires it. On retire it computes the next PC from the `pc_op` produced by control and starts the next fetch.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word aligned.

Ports:
- `clk`  input  1  core clock; all state on rising edge.
- `rst_n`  input  1  reset. Asynchronous assert, active-low.
- `imem_req`  output  1  fetch request to instruction memory.
- `imem_addr`  output  32  byte address of the requested word.
- `imem_ack`  input  1  memory response; `imem_rdata` is valid in this cycle.
- `imem_rdata`  input  32  fetched instruction word.
- `retire`  input  1  core has completed the held instruction this cycle.
- `pc_op`  input  `PC_OP_W`  next-PC select from control.
- `imm_b`  input  32  sign-extended B-type immediate.
- `imm_j`  input  32  sign-extended J-type immediate.
- `imm_i`  input  32  sign-extended I-type immediate, used for JALR.
- `rs1_data`  input  32  rs1 value, used for JALR.
- `inst_valid`  output  1  `inst` holds a fetched instruction awaiting retire.
- `inst`  output  32  held instruction word; `INSTRUCTION_NOP` (32'h0000_0013) when not valid.
- `opcode`  output  `INSTRUCTION_OPCODE_W`  `inst[6:0]`.
- `funct3`  output  `INSTRUCTION_FUNCT3_W`  `inst[14:12]`.
- `funct7`  output  `INSTRUCTION_FUNCT7_W`  `inst[31:25]`.
- `pc`  output  32  address of the held instruction.
- `pc_plus4`  output  32  `pc + 4`, the link value for JAL/JALR.
- `fetch_misaligned`  output  1  sticky flag: a computed target had `[1:0] != 0`.

## Operation

- States: IDLE, FETCH, HOLD, HALT.
- Reset values:
  - state IDLE, `pc = RESET_PC`, `inst = INSTRUCTION_NOP`.
  - `inst_valid = 0`, `imem_req = 0`, `fetch_misaligned = 0`.
- IDLE:
  - `imem_req = 0`.
  - Next cycle: FETCH.
  - Any `imem_ack` in IDLE is ignored.
- FETCH:
  - `imem_req = 1`, `imem_addr = pc`. Both stay stable until ack.
  - On `imem_ack`: `inst <= imem_rdata`, `inst_valid <= 1`, go to HOLD.
  - `retire` is ignored in FETCH.
- HOLD:
  - `imem_req = 0`. `inst`, `pc` and the field outputs are stable.
  - On `retire`, compute `next_pc` (mod 2^32):
    - `PC_OP_DEFAULT`: `pc + 4`.
    - `PC_OP_BRANCH`: `pc + imm_b`.
    - `PC_OP_JAL`: `pc + imm_j`.
    - `PC_OP_JALR`: `(rs1_data + imm_i) & ~32'h1`.
    - Any other code: `pc + 4`.
  - If `next_pc[1:0] == 0`: `pc <= next_pc`, `inst <= NOP`, `inst_valid <= 0`, go to FETCH.
  - Otherwise: `fetch_misaligned <= 1`, `inst <= NOP`, `inst_valid <= 0`, `pc` unchanged, go to HALT.
- HALT: terminal. No requests issued. Left only by reset.
- Wrap-around: `pc = 32'hFFFF_FFFC` with DEFAULT gives `next_pc = 0`. This is legal.
- `imem_ack` outside FETCH is ignored.
- Only the low 2 bits of `pc_op` encodings defined in `pc.vh` are decoded.

## Timing

- `imem_ack` may arrive in the same cycle `imem_req` rises (zero-wait memory) or any number of cycles later.
- Fetch latency: `inst_valid` rises on the edge that samples `imem_ack`.
- Minimum instruction period: 2 cycles (FETCH with immediate ack, then HOLD with immediate retire).
- `next_pc` uses the `pc_op`, immediates and `rs1_data` present in the retire cycle. Control is combinational from the held `inst`, so these are consistent.
- Reset asserted mid-fetch: `imem_req` drops asynchronously. Fetch restarts from `RESET_PC` two cycles after deassertion; the outstanding ack is not waited for.
- All outputs are registered or decoded directly from registers; there are no combinational paths from inputs to outputs.

## Structure

- `pc.vh`: `PC_OP_W` and the `PC_OP_*` encodings, shared with control.
- `instruction.vh`: field widths, `INSTRUCTION_NOP`, and the field bit positions.
- `common.vh`: `ENABLE` / `DISABLE`.
- Local FSM state encodings stay in the module.
- Sub-module `pc_next`: combinational next-PC adder/mux, plus the misalign check. Reused by the future branch-predict work.

## Test plan

- Reset with `RESET_PC = 32'h100`, ack in the same cycle as req → `imem_addr = 0x100` on the 2nd cycle after `rst_n` rises; `inst_valid = 1` the next cycle; `opcode`/`funct3`/`funct7` match `imem_rdata = 32'h40B5_0533` (0x33 / 0 / 0x20).
- Ack delayed 3 cycles → `imem_req` and `imem_addr` held stable 4 cycles; `inst_valid` stays 0 until the ack edge.
- In HOLD at `pc = 0x200`, `retire` with each op: BRANCH `imm_b = -8` → 0x1F8; JAL `imm_j = 0x40` → 0x240; JALR `rs1 = 0x1003`, `imm_i = 0` → 0x1002 (misaligned: flag set, HALT, no further req); DEFAULT → 0x204.
- `pc = 0xFFFF_FFFC`, DEFAULT retire → next `imem_addr = 0x0000_0000`; `fetch_misaligned` stays 0.
- Stray `imem_ack` in HOLD and IDLE, and `retire` in FETCH → no state change; `inst` unchanged.
- `rst_n` low while `imem_req = 1` → `imem_req` 0 immediately; after release, fetch resumes at `RESET_PC`.
